// File: rtl/rv_wb_stage.sv
// rv_wb_stage: MEM/WB pipeline register and RV32I writeback stage.
// Optional instret counter: define RV_WB_INSTRET_EN.
//
// Ports:
//   i_wb_clk, i_wb_rstn            clock (posedge), async active-low reset
//   i_wb_valid/stall/flush         MEM valid, hazard hold, kill
//   i_wb_rd, i_wb_rd_we, i_wb_src  dest reg, write enable, wb source select
//   i_wb_alu_res/pc4/imm           candidate writeback values (alu_res = load addr)
//   i_wb_funct3                    load size/sign
//   i_wb_dmem_rdata                sync dmem word, valid in first WB cycle only
//   o_wb_rf_wd/wa/we               regfile write port
//   o_wb_misalign                  misaligned load flag
//   o_wb_retire                    one-cycle pulse when instruction leaves WB
//   o_wb_instret                   64-bit retire count (RV_WB_INSTRET_EN only)

`ifndef XLEN
`define XLEN 32
`endif

module rv_wb_stage (
   input  logic             i_wb_clk,
   input  logic             i_wb_rstn,
   input  logic             i_wb_valid,
   input  logic             i_wb_stall,
   input  logic             i_wb_flush,
   input  logic [4:0]       i_wb_rd,
   input  logic             i_wb_rd_we,
   input  logic [1:0]       i_wb_src,
   input  logic [`XLEN-1:0] i_wb_alu_res,
   input  logic [`XLEN-1:0] i_wb_pc4,
   input  logic [`XLEN-1:0] i_wb_imm,
   input  logic [2:0]       i_wb_funct3,
   input  logic [`XLEN-1:0] i_wb_dmem_rdata,
   output logic [`XLEN-1:0] o_wb_rf_wd,
   output logic [4:0]       o_wb_rf_wa,
   output logic             o_wb_rf_we,
   output logic             o_wb_misalign,
   output logic             o_wb_retire
`ifdef RV_WB_INSTRET_EN
  ,output logic [63:0]      o_wb_instret
`endif
);

   localparam int XLEN = `XLEN;

   logic            valid_q;
   logic [4:0]      rd_q;
   logic            rd_we_q;
   logic [1:0]      src_q;
   logic [XLEN-1:0] alu_res_q;
   logic [XLEN-1:0] pc4_q;
   logic [XLEN-1:0] imm_q;
   logic [2:0]      funct3_q;
   logic            first_q;
   logic [XLEN-1:0] hold_q;

   logic [1:0]      addr_lo;
   logic            is_byte;
   logic            is_half;
   logic            is_word;
   logic            is_signed;
   logic [7:0]      byte_lane;
   logic [15:0]     half_lane;
   logic [XLEN-1:0] ext;
   logic [XLEN-1:0] load_data;
   logic            misalign;

   always_ff @(posedge i_wb_clk or negedge i_wb_rstn) begin
      if (!i_wb_rstn) begin
         valid_q   <= 1'b0;
         rd_q      <= '0;
         rd_we_q   <= 1'b0;
         src_q     <= '0;
         alu_res_q <= '0;
         pc4_q     <= '0;
         imm_q     <= '0;
         funct3_q  <= '0;
         first_q   <= 1'b0;
         hold_q    <= '0;
      end else if (i_wb_flush) begin
         valid_q <= 1'b0;
         first_q <= 1'b0;
      end else if (i_wb_stall) begin
         // dmem word is only valid in the first cycle; latch the
         // extracted value so a long stall keeps wd stable.
         first_q <= 1'b0;
         if (first_q) hold_q <= ext;
      end else begin
         valid_q   <= i_wb_valid;
         rd_q      <= i_wb_rd;
         rd_we_q   <= i_wb_rd_we;
         src_q     <= i_wb_src;
         alu_res_q <= i_wb_alu_res;
         pc4_q     <= i_wb_pc4;
         imm_q     <= i_wb_imm;
         funct3_q  <= i_wb_funct3;
         first_q   <= 1'b1;
      end
   end

   assign addr_lo   = alu_res_q[1:0];
   assign is_byte   = (funct3_q[1:0] == 2'b00);
   assign is_half   = (funct3_q[1:0] == 2'b01);
   // 010, 011, 110, 111 all behave as LW
   assign is_word   = funct3_q[1];
   assign is_signed = ~funct3_q[2];
   assign byte_lane = i_wb_dmem_rdata[{addr_lo, 3'b000} +: 8];
   assign half_lane = i_wb_dmem_rdata[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      ext = i_wb_dmem_rdata;
      unique case (1'b1)
         is_byte: ext = {{(XLEN-8){is_signed & byte_lane[7]}}, byte_lane};
         is_half: ext = {{(XLEN-16){is_signed & half_lane[15]}}, half_lane};
         is_word: ext = i_wb_dmem_rdata;
         default: ext = i_wb_dmem_rdata;
      endcase
   end

   assign load_data = first_q ? ext : hold_q;

   assign misalign = valid_q & (src_q == 2'b01) &
                     ((is_half & addr_lo[0]) |
                      (is_word & (addr_lo != 2'b00)));

   always_comb begin
      o_wb_rf_wd = alu_res_q;
      unique case (src_q)
         2'b00:   o_wb_rf_wd = alu_res_q;
         2'b01:   o_wb_rf_wd = load_data;
         2'b10:   o_wb_rf_wd = pc4_q;
         2'b11:   o_wb_rf_wd = imm_q;
         default: o_wb_rf_wd = alu_res_q;
      endcase
   end

   assign o_wb_rf_wa    = rd_q;
   assign o_wb_rf_we    = valid_q & rd_we_q & (rd_q != 5'd0) & ~misalign;
   assign o_wb_misalign = misalign;
   assign o_wb_retire   = valid_q & ~i_wb_stall & ~i_wb_flush;

`ifdef RV_WB_INSTRET_EN
   always_ff @(posedge i_wb_clk or negedge i_wb_rstn) begin
      if (!i_wb_rstn)       o_wb_instret <= '0;
      else if (o_wb_retire) o_wb_instret <= o_wb_instret + 64'd1;
   end
`endif

endmodule

// File: tb/tb_rv_wb_stage.sv
// tb_rv_wb_stage: directed self-checking bench for rv_wb_stage.
// Inputs driven on negedge / just after posedge; outputs sampled #1 later.

`timescale 1ns/1ps

module tb_rv_wb_stage;

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic        stall;
   logic        flush;
   logic [4:0]  rd;
   logic        rd_we;
   logic [1:0]  src;
   logic [31:0] alu_res;
   logic [31:0] pc4;
   logic [31:0] imm;
   logic [2:0]  funct3;
   logic [31:0] rdata;
   logic [31:0] wd;
   logic [4:0]  wa;
   logic        we;
   logic        misalign;
   logic        retire;
`ifdef RV_WB_INSTRET_EN
   logic [63:0] instret;
`endif

   int total = 0;
   int bad   = 0;

   rv_wb_stage dut (
      .i_wb_clk        (clk),
      .i_wb_rstn       (rst_n),
      .i_wb_valid      (valid),
      .i_wb_stall      (stall),
      .i_wb_flush      (flush),
      .i_wb_rd         (rd),
      .i_wb_rd_we      (rd_we),
      .i_wb_src        (src),
      .i_wb_alu_res    (alu_res),
      .i_wb_pc4        (pc4),
      .i_wb_imm        (imm),
      .i_wb_funct3     (funct3),
      .i_wb_dmem_rdata (rdata),
      .o_wb_rf_wd      (wd),
      .o_wb_rf_wa      (wa),
      .o_wb_rf_we      (we),
      .o_wb_misalign   (misalign),
      .o_wb_retire     (retire)
`ifdef RV_WB_INSTRET_EN
     ,.o_wb_instret    (instret)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic capture(input logic [4:0] r, input logic [1:0] s,
                          input logic [31:0] a, input logic [2:0] f3);
      @(negedge clk);
      valid   = 1'b1;
      rd      = r;
      rd_we   = 1'b1;
      src     = s;
      alu_res = a;
      funct3  = f3;
      @(posedge clk);
      #1;
      valid = 1'b0;
      rdata = 32'h80FF7F01;
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #3;
      total++;
      if ({wd, wa, we, misalign, retire} !== 40'd0) begin
         bad++;
         $display("FAIL reset: wd=%h wa=%0d we=%b mis=%b ret=%b want all 0",
                  wd, wa, we, misalign, retire);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_alu;
      capture(5'd5, 2'b00, 32'h1234, 3'b000);
      total++;
      if (wa !== 5'd5) begin
         bad++; $display("FAIL alu_wa: got %0d want 5", wa);
      end
      total++;
      if (wd !== 32'h1234) begin
         bad++; $display("FAIL alu_wd: got %h want 00001234", wd);
      end
      total++;
      if (we !== 1'b1) begin
         bad++; $display("FAIL alu_we: got %b want 1", we);
      end
      total++;
      if (retire !== 1'b1) begin
         bad++; $display("FAIL alu_retire: got %b want 1", retire);
      end
   endtask

   task automatic test_x0;
      capture(5'd0, 2'b00, 32'hABCD, 3'b000);
      total++;
      if (we !== 1'b0) begin
         bad++; $display("FAIL x0_we: got %b want 0", we);
      end
      total++;
      if (retire !== 1'b1) begin
         bad++; $display("FAIL x0_retire: got %b want 1", retire);
      end
   endtask

   task automatic test_pc4_imm;
      pc4 = 32'h0000_1004;
      imm = 32'hABCDE000;
      capture(5'd1, 2'b10, 32'h0, 3'b000);
      total++;
      if (wd !== 32'h0000_1004) begin
         bad++; $display("FAIL pc4_wd: got %h want 00001004", wd);
      end
      capture(5'd2, 2'b11, 32'h0, 3'b000);
      total++;
      if (wd !== 32'hABCDE000) begin
         bad++; $display("FAIL imm_wd: got %h want abcde000", wd);
      end
   endtask

   task automatic test_load;
      logic [2:0]  f3v  [9] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101,
                                3'b010, 3'b000, 3'b001, 3'b111};
      logic [1:0]  av   [9] = '{2'd0, 2'd3, 2'd3, 2'd2, 2'd2,
                                2'd0, 2'd1, 2'd0, 2'd0};
      logic [31:0] expv [9] = '{32'h00000001, 32'hFFFFFF80, 32'h00000080,
                                32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01,
                                32'h0000007F, 32'h00007F01, 32'h80FF7F01};
      for (int i = 0; i < 9; i++) begin
         capture(5'd3, 2'b01, {30'h100, av[i]}, f3v[i]);
         total++;
         if (wd !== expv[i] || we !== 1'b1 || misalign !== 1'b0) begin
            bad++;
            $display("FAIL load[%0d] f3=%b a=%0d: wd=%h we=%b mis=%b want %h 1 0",
                     i, f3v[i], av[i], wd, we, misalign, expv[i]);
         end
      end
   endtask

   task automatic test_misalign;
      logic [2:0] f3v [3] = '{3'b001, 3'b010, 3'b101};
      logic [1:0] av  [3] = '{2'd1, 2'd2, 2'd3};
      for (int i = 0; i < 3; i++) begin
         capture(5'd6, 2'b01, {30'h200, av[i]}, f3v[i]);
         total++;
         if (misalign !== 1'b1 || we !== 1'b0 || retire !== 1'b1) begin
            bad++;
            $display("FAIL misalign[%0d]: mis=%b we=%b ret=%b want 1 0 1",
                     i, misalign, we, retire);
         end
      end
      // ALU result with odd low bits must not flag
      capture(5'd6, 2'b00, 32'h3, 3'b010);
      total++;
      if (misalign !== 1'b0 || we !== 1'b1) begin
         bad++;
         $display("FAIL misalign_alu: mis=%b we=%b want 0 1", misalign, we);
      end
   endtask

   task automatic test_stall_load;
      int pulses = 0;
      @(negedge clk);
      valid   = 1'b1;
      rd      = 5'd7;
      rd_we   = 1'b1;
      src     = 2'b01;
      alu_res = 32'h400;
      funct3  = 3'b010;
      @(posedge clk);
      #1;
      valid = 1'b0;
      rdata = 32'h80FF7F01;
      stall = 1'b1;
      #1;
      pulses += int'(retire);
      total++;
      if (wd !== 32'h80FF7F01 || we !== 1'b1) begin
         bad++; $display("FAIL stall_c0: wd=%h we=%b want 80ff7f01 1", wd, we);
      end
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk);
         #1;
         rdata = 32'hDEADBEEF;
         if (c == 3) stall = 1'b0;
         #1;
         pulses += int'(retire);
         total++;
         if (wd !== 32'h80FF7F01 || we !== 1'b1) begin
            bad++;
            $display("FAIL stall_c%0d: wd=%h we=%b want 80ff7f01 1", c, wd, we);
         end
      end
      total++;
      if (retire !== 1'b1) begin
         bad++; $display("FAIL stall_release: retire=%b want 1", retire);
      end
      @(posedge clk);
      #2;
      pulses += int'(retire);
      total++;
      if (pulses != 1 || we !== 1'b0) begin
         bad++; $display("FAIL stall_pulses: got %0d we=%b want 1 0", pulses, we);
      end
   endtask

   task automatic test_flush_stall;
      capture(5'd9, 2'b00, 32'h99, 3'b000);
      stall = 1'b1;
      flush = 1'b1;
      #1;
      total++;
      if (retire !== 1'b0) begin
         bad++; $display("FAIL flush_retire_same: got %b want 0", retire);
      end
      @(posedge clk);
      #1;
      total++;
      if (we !== 1'b0 || retire !== 1'b0) begin
         bad++; $display("FAIL flush_after: we=%b ret=%b want 0 0", we, retire);
      end
      stall = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      @(negedge clk);
      valid = 1'b1;
      rd_we = 1'b1;
      src   = 2'b00;
      for (int i = 0; i < 4; i++) begin
         rd      = 5'(10 + i);
         alu_res = vals[i];
         @(posedge clk);
         #1;
         total++;
         if (wd !== vals[i] || wa !== 5'(10 + i) || retire !== 1'b1) begin
            bad++;
            $display("FAIL b2b[%0d]: wd=%h wa=%0d ret=%b want %h %0d 1",
                     i, wd, wa, retire, vals[i], 10 + i);
         end
      end
      valid = 1'b0;
   endtask

   task automatic test_async_reset_stall;
      capture(5'd4, 2'b00, 32'h55, 3'b000);
      stall = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({wd, wa, we, misalign, retire} !== 40'd0) begin
         bad++;
         $display("FAIL async_rst: wd=%h wa=%0d we=%b mis=%b ret=%b want 0",
                  wd, wa, we, misalign, retire);
      end
      @(negedge clk);
      stall = 1'b0;
      rst_n = 1'b1;
   endtask

`ifdef RV_WB_INSTRET_EN
   task automatic test_instret;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if (instret !== 64'd0) begin
         bad++; $display("FAIL instret_rst0: got %0d want 0", instret);
      end
      @(negedge clk);
      rst_n = 1'b1;
      valid = 1'b1;
      rd    = 5'd8;
      src   = 2'b00;
      repeat (10) @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (instret !== 64'd10) begin
         bad++; $display("FAIL instret_10: got %0d want 10", instret);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (instret !== 64'd0) begin
         bad++; $display("FAIL instret_rst: got %0d want 0", instret);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask
`endif

   initial begin
      valid   = 1'b0;
      stall   = 1'b0;
      flush   = 1'b0;
      rd      = '0;
      rd_we   = 1'b0;
      src     = '0;
      alu_res = '0;
      pc4     = '0;
      imm     = '0;
      funct3  = '0;
      rdata   = '0;
      test_reset();
      test_alu();
      test_x0();
      test_pc4_imm();
      test_load();
      test_misalign();
      test_stall_load();
      test_flush_stall();
      test_back_to_back();
      test_async_reset_stall();
`ifdef RV_WB_INSTRET_EN
      test_instret();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
